// File: rtl/ysyx_25040129_axi_arbiter_if.sv
// AXI4 bundle (AR/R/AW/W/B) shared by the arbiter's upstream and downstream ports.
// master drives requests; slave returns ready/response signals.
interface ysyx_25040129_axi_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output arvalid, araddr, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast,
        output rready,
        output awvalid, awaddr, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast,
        input  rready,
        input  awvalid, awaddr, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/ysyx_25040129_axi_arbiter.sv
// 2:1 AXI4 arbiter, IFU (m0, read-only) and LSU (m1) onto one io_master port.
// Define YSYX_25040129_ARB_ROUND_ROBIN_EN for round-robin; default is m1-first.
module ysyx_25040129_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    ysyx_25040129_axi_arbiter_if.slave    m0,
    ysyx_25040129_axi_arbiter_if.slave    m1,
    ysyx_25040129_axi_arbiter_if.master   out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_WR,
        S_B
    } state_e;

    state_e state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
    logic   req_m1, pick_m1;
    logic   aw_fire, w_fire;

    logic [ADDR_W-1:0] ar_addr;
    logic [DATA_W-1:0] r_data;

    logic unused_m0;
    assign unused_m0 = ^{m0.awvalid, m0.awaddr, m0.awlen, m0.awsize,
                         m0.awburst, m0.wvalid, m0.wdata, m0.wstrb,
                         m0.wlast, m0.bready};

    assign req_m1  = m1.arvalid | m1.awvalid;
    assign ar_addr = gnt_q ? m1.araddr : m0.araddr;
    assign r_data  = out.rdata;

`ifdef YSYX_25040129_ARB_ROUND_ROBIN_EN
    // ptr_q names the master that wins a tie; it moves off the last winner
    logic ptr_q, ptr_d;
    assign pick_m1 = req_m1 & (~m0.arvalid | ptr_q);
`else
    assign pick_m1 = req_m1;
`endif

    assign aw_fire = m1.awvalid & ~aw_done_q & out.awready;
    assign w_fire  = m1.wvalid  & ~w_done_q  & out.wready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef YSYX_25040129_ARB_ROUND_ROBIN_EN
            ptr_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef YSYX_25040129_ARB_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef YSYX_25040129_ARB_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        out.arvalid = 1'b0;
        out.araddr  = '0;
        out.arlen   = '0;
        out.arsize  = '0;
        out.arburst = '0;
        out.rready  = 1'b0;
        out.awvalid = 1'b0;
        out.awaddr  = '0;
        out.awlen   = '0;
        out.awsize  = '0;
        out.awburst = '0;
        out.wvalid  = 1'b0;
        out.wdata   = '0;
        out.wstrb   = '0;
        out.wlast   = 1'b0;
        out.bready  = 1'b0;
        m0.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m0.rdata   = '0;
        m0.rresp   = '0;
        m0.rlast   = 1'b0;
        m0.awready = 1'b0;
        m0.wready  = 1'b0;
        m0.bvalid  = 1'b0;
        m0.bresp   = '0;
        m1.arready = 1'b0;
        m1.rvalid  = 1'b0;
        m1.rdata   = '0;
        m1.rresp   = '0;
        m1.rlast   = 1'b0;
        m1.awready = 1'b0;
        m1.wready  = 1'b0;
        m1.bvalid  = 1'b0;
        m1.bresp   = '0;

        unique case (state_q)
            S_IDLE: begin
                if (pick_m1) begin
                    gnt_d   = 1'b1;
                    state_d = m1.awvalid ? S_WR : S_AR;
                end else if (m0.arvalid) begin
                    gnt_d   = 1'b0;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                out.arvalid = gnt_q ? m1.arvalid : m0.arvalid;
                out.araddr  = ar_addr;
                out.arlen   = gnt_q ? m1.arlen   : m0.arlen;
                out.arsize  = gnt_q ? m1.arsize  : m0.arsize;
                out.arburst = gnt_q ? m1.arburst : m0.arburst;
                if (gnt_q) m1.arready = out.arready;
                else       m0.arready = out.arready;
                if (out.arready && (gnt_q ? m1.arvalid : m0.arvalid))
                    state_d = S_R;
            end
            S_R: begin
                out.rready = gnt_q ? m1.rready : m0.rready;
                if (gnt_q) begin
                    m1.rvalid = out.rvalid;
                    m1.rdata  = r_data;
                    m1.rresp  = out.rresp;
                    m1.rlast  = out.rlast;
                end else begin
                    m0.rvalid = out.rvalid;
                    m0.rdata  = r_data;
                    m0.rresp  = out.rresp;
                    m0.rlast  = out.rlast;
                end
                if (out.rvalid && (gnt_q ? m1.rready : m0.rready) && out.rlast) begin
                    state_d = S_IDLE;
`ifdef YSYX_25040129_ARB_ROUND_ROBIN_EN
                    ptr_d   = ~gnt_q;
`endif
                end
            end
            S_WR: begin
                // AW and W are independent; a finished channel is masked off
                out.awvalid = m1.awvalid & ~aw_done_q;
                out.awaddr  = m1.awaddr;
                out.awlen   = m1.awlen;
                out.awsize  = m1.awsize;
                out.awburst = m1.awburst;
                out.wvalid  = m1.wvalid & ~w_done_q;
                out.wdata   = m1.wdata;
                out.wstrb   = m1.wstrb;
                out.wlast   = m1.wlast;
                m1.awready  = out.awready & ~aw_done_q;
                m1.wready   = out.wready & ~w_done_q;
                aw_done_d   = aw_done_q | aw_fire;
                w_done_d    = w_done_q | w_fire;
                if (aw_done_d && w_done_d) begin
                    state_d   = S_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            S_B: begin
                m1.bvalid  = out.bvalid;
                m1.bresp   = out.bresp;
                out.bready = m1.bready;
                if (out.bvalid && m1.bready) begin
                    state_d = S_IDLE;
`ifdef YSYX_25040129_ARB_ROUND_ROBIN_EN
                    ptr_d   = 1'b0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
